sfifo_param: RTL and testbench

SFIFO_PARAM -- requirements
Module: sfifo_param

---
 rtl/sfifo_param_if.sv | 29 ++
 rtl/sfifo_param.sv | 93 +++++++++
 tb/tb_sfifo_param.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sfifo_param_if.sv
// Write/read handshake, data and status bundle for sfifo_param.
// The testbench or parent drives the master side; the FIFO is the slave.
interface sfifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [ADDR_SIZE:0]    count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sfifo_param.sv
// Single-clock parameterised FIFO with registered fill count, almost flags,
// sticky overflow/underflow and a selectable standard or first-word-fall-through read.
module sfifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_SIZE     = 4,
  parameter int AFULL_THRESH  = (2**ADDR_SIZE) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic          wclk,
  input  logic          wrst_n,
  sfifo_param_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] C_DEPTH  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] C_AFULL  = (ADDR_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] C_AEMPTY = (ADDR_SIZE+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE:0]    r_wptr;
  logic [ADDR_SIZE:0]    r_rptr;
  logic [ADDR_SIZE:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_SIZE-1:0]  w_waddr;
  logic [ADDR_SIZE-1:0]  w_raddr;

  // Status comes only from the registered count, never from the request inputs.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_waddr = r_wptr[ADDR_SIZE-1:0];
  assign w_raddr = r_rptr[ADDR_SIZE-1:0];

  // Reset gates the memory write too, so a transfer in a reset cycle is aborted.
  assign w_wr_en = bus.winc & ~w_full & wrst_n;
  assign w_rd_en = bus.rinc & ~w_empty;

  always_ff @(posedge wclk) begin
    if (w_wr_en)
      r_mem[w_waddr] <= bus.wdata;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd_en)
        r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new error event takes priority over a coincident clear.
      r_overflow  <= (bus.winc & w_full)  | (r_overflow  & ~bus.clr_err);
      r_underflow <= (bus.rinc & w_empty) | (r_underflow & ~bus.clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rdata = w_empty ? '0 : r_mem[w_raddr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rdata;
      always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
          r_rdata <= '0;
        else if (w_rd_en)
          r_rdata <= r_mem[w_raddr];
      end
      assign bus.rdata = r_rdata;
    end
  endgenerate

  assign bus.wfull         = w_full;
  assign bus.rempty        = w_empty;
  assign bus.walmost_full  = (r_count >= C_AFULL);
  assign bus.ralmost_empty = (r_count <= C_AEMPTY);
  assign bus.count         = r_count;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_sfifo_param.sv
// Self-checking bench for sfifo_param: a standard-read instance driven by a
// vector table plus stream/reset sequences, and a FWFT instance for fall-through.
module tb_sfifo_param;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sfifo_param_if #(.DATA_WIDTH(8), .ADDR_SIZE(4)) bus0 ();
  sfifo_param_if #(.DATA_WIDTH(8), .ADDR_SIZE(4)) bus1 ();

  sfifo_param #(.DATA_WIDTH(8), .ADDR_SIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b0))
    dut0 (.wclk(clk), .wrst_n(rst_n), .bus(bus0));

  sfifo_param #(.DATA_WIDTH(8), .ADDR_SIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b1))
    dut1 (.wclk(clk), .wrst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic       clr;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_afull;
    logic       e_empty;
    logic       e_aempty;
    logic       e_ovf;
    logic       e_unf;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] model_q[$];

  // Expected flags follow the definitions for DEPTH=16, AFULL=14, AEMPTY=2.
  function automatic vec_t row(logic winc, logic [7:0] wdata, logic rinc, logic clr,
                               int cnt, logic ovf, logic unf, logic [7:0] rd);
    vec_t v;
    v.winc     = winc;
    v.wdata    = wdata;
    v.rinc     = rinc;
    v.clr      = clr;
    v.e_count  = 5'(cnt);
    v.e_full   = (cnt == 16);
    v.e_afull  = (cnt >= 14);
    v.e_empty  = (cnt == 0);
    v.e_aempty = (cnt <= 2);
    v.e_ovf    = ovf;
    v.e_unf    = unf;
    v.e_rdata  = rd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk0(string tag, vec_t v);
    chk({tag, " count"},   32'(bus0.count),         32'(v.e_count));
    chk({tag, " wfull"},   32'(bus0.wfull),         32'(v.e_full));
    chk({tag, " afull"},   32'(bus0.walmost_full),  32'(v.e_afull));
    chk({tag, " rempty"},  32'(bus0.rempty),        32'(v.e_empty));
    chk({tag, " aempty"},  32'(bus0.ralmost_empty), 32'(v.e_aempty));
    chk({tag, " ovf"},     32'(bus0.overflow),      32'(v.e_ovf));
    chk({tag, " unf"},     32'(bus0.underflow),     32'(v.e_unf));
    chk({tag, " rdata"},   32'(bus0.rdata),         32'(v.e_rdata));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.winc = 1'b0; bus0.wdata = 8'h00; bus0.rinc = 1'b0; bus0.clr_err = 1'b0;
    bus1.winc = 1'b0; bus1.wdata = 8'h00; bus1.rinc = 1'b0; bus1.clr_err = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [7:0] exp_rd;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Table: fill, full push+pop, clear, drain, empty corner cases.
    for (int i = 1; i <= 16; i++)
      vecs.push_back(row(1'b1, 8'(i), 1'b0, 1'b0, i, 1'b0, 1'b0, 8'h00));
    vecs.push_back(row(1'b1, 8'hEE, 1'b1, 1'b0, 15, 1'b1, 1'b0, 8'h01));
    vecs.push_back(row(1'b0, 8'h00, 1'b0, 1'b1, 15, 1'b0, 1'b0, 8'h01));
    for (int k = 2; k <= 16; k++)
      vecs.push_back(row(1'b0, 8'h00, 1'b1, 1'b0, 16 - k, 1'b0, 1'b0, 8'(k)));
    vecs.push_back(row(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h10));
    vecs.push_back(row(1'b1, 8'hA5, 1'b1, 1'b1, 1, 1'b0, 1'b1, 8'h10));
    vecs.push_back(row(1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'h10));
    vecs.push_back(row(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'hA5));

    #12;
    chk0("reset", row(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00));
    chk("reset fwft rempty", 32'(bus1.rempty), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      bus0.winc = v.winc; bus0.wdata = v.wdata; bus0.rinc = v.rinc; bus0.clr_err = v.clr;
      step();
      $display("vec %0d: winc=%0b wdata=%02h rinc=%0b clr=%0b -> count=%0d rdata=%02h",
               i, v.winc, v.wdata, v.rinc, v.clr, bus0.count, bus0.rdata);
      chk0($sformatf("vec%0d", i), v);
    end
    idle_inputs();

    // Stream at count=8 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      bus0.winc = 1'b1; bus0.wdata = 8'(8'h30 + i);
      model_q.push_back(8'(8'h30 + i));
      step();
    end
    chk("prefill count", 32'(bus0.count), 32'd8);
    for (int c = 0; c < 40; c++) begin
      if (c == 25) begin
        #3;
        rst_n = 1'b0;
        #1;
        $display("stream cycle %0d: async reset asserted", c);
        chk0("midreset", row(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00));
        idle_inputs();
        step();
        chk0("inreset", row(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00));
        rst_n = 1'b1;
        break;
      end
      bus0.winc = 1'b1; bus0.rinc = 1'b1; bus0.wdata = 8'(8'h40 + c);
      model_q.push_back(8'(8'h40 + c));
      exp_rd = model_q.pop_front();
      step();
      $display("stream cycle %0d: wdata=%02h count=%0d rdata=%02h", c, bus0.wdata, bus0.count, bus0.rdata);
      chk($sformatf("stream%0d count", c), 32'(bus0.count), 32'd8);
      chk($sformatf("stream%0d rdata", c), 32'(bus0.rdata), 32'(exp_rd));
    end

    // Data written before reset must not be readable afterwards.
    bus0.rinc = 1'b1;
    step();
    $display("post-reset read: count=%0d rdata=%02h unf=%0b", bus0.count, bus0.rdata, bus0.underflow);
    chk0("postreset rd", row(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h00));
    bus0.rinc = 1'b0; bus0.clr_err = 1'b1;
    step();
    chk("postreset clr unf", 32'(bus0.underflow), 32'd0);
    idle_inputs();

    // FWFT instance: underflow on empty, then fall-through data.
    bus1.rinc = 1'b1;
    step();
    $display("fwft read on empty: unf=%0b count=%0d", bus1.underflow, bus1.count);
    chk("fwft unf", 32'(bus1.underflow), 32'd1);
    chk("fwft unf count", 32'(bus1.count), 32'd0);
    bus1.rinc = 1'b0; bus1.winc = 1'b1; bus1.wdata = 8'hA5;
    step();
    $display("fwft write A5: rempty=%0b rdata=%02h", bus1.rempty, bus1.rdata);
    chk("fwft rempty", 32'(bus1.rempty), 32'd0);
    chk("fwft rdata A5", 32'(bus1.rdata), 32'hA5);
    bus1.wdata = 8'h5A;
    step();
    $display("fwft write 5A: count=%0d rdata=%02h", bus1.count, bus1.rdata);
    chk("fwft count2", 32'(bus1.count), 32'd2);
    chk("fwft head held", 32'(bus1.rdata), 32'hA5);
    bus1.winc = 1'b0; bus1.rinc = 1'b1;
    step();
    $display("fwft pop: count=%0d rdata=%02h", bus1.count, bus1.rdata);
    chk("fwft next rdata", 32'(bus1.rdata), 32'h5A);
    chk("fwft count1", 32'(bus1.count), 32'd1);
    step();
    $display("fwft pop: count=%0d rempty=%0b", bus1.count, bus1.rempty);
    chk("fwft drained", 32'(bus1.rempty), 32'd1);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
